// File: rtl/tlb_port_arbiter_if.sv
// Request/response bundle between the fetch/data requesters, the shared
// TLB lookup port and the arbiter.
interface tlb_port_arbiter_if;
    logic        inst_req_i;
    logic [31:0] inst_vaddr_i;
    logic        inst_gnt_o;
    logic        inst_rvalid_o;
    logic [31:0] inst_paddr_o;
    logic        inst_miss_o;
    logic        inst_invalid_o;
    logic        inst_cache_o;

    logic        data_req_i;
    logic [31:0] data_vaddr_i;
    logic        data_ren_i;
    logic        data_wen_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_paddr_o;
    logic        data_miss_o;
    logic        data_invalid_o;
    logic        data_modified_o;
    logic        data_cache_o;

    logic        flush_i;
    logic        tlb_write_i;

    logic        tlb_valid_o;
    logic [31:0] tlb_vaddr_o;
    logic        tlb_ren_o;
    logic        tlb_wen_o;
    logic [31:0] tlb_paddr_i;
    logic        tlb_miss_i;
    logic        tlb_invalid_i;
    logic        tlb_modified_i;
    logic        tlb_cache_i;

    modport slave (
        input  inst_req_i, inst_vaddr_i,
        output inst_gnt_o, inst_rvalid_o, inst_paddr_o,
        output inst_miss_o, inst_invalid_o, inst_cache_o,
        input  data_req_i, data_vaddr_i, data_ren_i, data_wen_i,
        output data_gnt_o, data_rvalid_o, data_paddr_o,
        output data_miss_o, data_invalid_o, data_modified_o, data_cache_o,
        input  flush_i, tlb_write_i,
        output tlb_valid_o, tlb_vaddr_o, tlb_ren_o, tlb_wen_o,
        input  tlb_paddr_i, tlb_miss_i, tlb_invalid_i,
        input  tlb_modified_i, tlb_cache_i
    );

    modport master (
        output inst_req_i, inst_vaddr_i,
        input  inst_gnt_o, inst_rvalid_o, inst_paddr_o,
        input  inst_miss_o, inst_invalid_o, inst_cache_o,
        output data_req_i, data_vaddr_i, data_ren_i, data_wen_i,
        input  data_gnt_o, data_rvalid_o, data_paddr_o,
        input  data_miss_o, data_invalid_o, data_modified_o, data_cache_o,
        output flush_i, tlb_write_i,
        input  tlb_valid_o, tlb_vaddr_o, tlb_ren_o, tlb_wen_o,
        output tlb_paddr_i, tlb_miss_i, tlb_invalid_i,
        output tlb_modified_i, tlb_cache_i
    );
endinterface

// File: rtl/tlb_port_arbiter.sv
// Shares the joint TLB lookup port between instruction fetch and data
// memory; one lookup outstanding, data priority with starvation guard.
module tlb_port_arbiter #(
    parameter int LOOKUP_LAT = 1,
    parameter int STARVE_MAX = 4
) (
    input logic               clk,
    input logic               rst,
    tlb_port_arbiter_if.slave bus
);
    localparam int CW = (LOOKUP_LAT < 2) ? 1 : $clog2(LOOKUP_LAT + 1);
    localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] LAT_V    = CW'(LOOKUP_LAT);
    localparam logic [SW-1:0] STARVE_V = SW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          owner_q, owner_d;
    logic          valid_q, valid_d;
    logic [31:0]   vaddr_q, vaddr_d;
    logic          ren_q, ren_d;
    logic          wen_q, wen_d;
    logic          irv_q, irv_d;
    logic          drv_q, drv_d;
    logic [31:0]   ipaddr_q, ipaddr_d;
    logic          imiss_q, imiss_d;
    logic          iinv_q, iinv_d;
    logic          icache_q, icache_d;
    logic [31:0]   dpaddr_q, dpaddr_d;
    logic          dmiss_q, dmiss_d;
    logic          dinv_q, dinv_d;
    logic          dmod_q, dmod_d;
    logic          dcache_q, dcache_d;
    logic          inst_gnt, data_gnt, sample;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        starve_d = starve_q;
        owner_d  = owner_q;
        valid_d  = 1'b0;
        vaddr_d  = vaddr_q;
        ren_d    = ren_q;
        wen_d    = wen_q;
        irv_d    = 1'b0;
        drv_d    = 1'b0;
        ipaddr_d = ipaddr_q;
        imiss_d  = imiss_q;
        iinv_d   = iinv_q;
        icache_d = icache_q;
        dpaddr_d = dpaddr_q;
        dmiss_d  = dmiss_q;
        dinv_d   = dinv_q;
        dmod_d   = dmod_q;
        dcache_d = dcache_q;
        inst_gnt = 1'b0;
        data_gnt = 1'b0;
        sample   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rst && !bus.flush_i && !bus.tlb_write_i) begin
                    if (bus.data_req_i &&
                        !(bus.inst_req_i && starve_q == STARVE_V))
                        data_gnt = 1'b1;
                    else if (bus.inst_req_i)
                        inst_gnt = 1'b1;
                end
            end
            ISSUE: begin
                state_d = bus.flush_i ? IDLE : WAIT;
                cnt_d   = LAT_V;
            end
            WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (bus.flush_i) begin
                    state_d = IDLE;
                end else if (cnt_q == CW'(1)) begin
                    sample  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (inst_gnt || data_gnt) begin
            state_d = ISSUE;
            valid_d = 1'b1;
            owner_d = data_gnt;
            vaddr_d = data_gnt ? bus.data_vaddr_i : bus.inst_vaddr_i;
            ren_d   = data_gnt & bus.data_ren_i;
            wen_d   = data_gnt & bus.data_wen_i;
        end

        // Count only contested data wins; a fetch win resets the guard.
        if (data_gnt && bus.inst_req_i && starve_q != STARVE_V)
            starve_d = starve_q + SW'(1);
        if (inst_gnt)
            starve_d = '0;

        if (sample) begin
            irv_d = !owner_q;
            drv_d = owner_q;
            if (owner_q) begin
                dpaddr_d = bus.tlb_paddr_i;
                dmiss_d  = bus.tlb_miss_i;
                dinv_d   = bus.tlb_invalid_i;
                dmod_d   = bus.tlb_modified_i;
                dcache_d = bus.tlb_cache_i;
            end else begin
                ipaddr_d = bus.tlb_paddr_i;
                imiss_d  = bus.tlb_miss_i;
                iinv_d   = bus.tlb_invalid_i;
                icache_d = bus.tlb_cache_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            starve_q <= '0;
            owner_q  <= 1'b0;
            valid_q  <= 1'b0;
            vaddr_q  <= '0;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            irv_q    <= 1'b0;
            drv_q    <= 1'b0;
            ipaddr_q <= '0;
            imiss_q  <= 1'b0;
            iinv_q   <= 1'b0;
            icache_q <= 1'b0;
            dpaddr_q <= '0;
            dmiss_q  <= 1'b0;
            dinv_q   <= 1'b0;
            dmod_q   <= 1'b0;
            dcache_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            owner_q  <= owner_d;
            valid_q  <= valid_d;
            vaddr_q  <= vaddr_d;
            ren_q    <= ren_d;
            wen_q    <= wen_d;
            irv_q    <= irv_d;
            drv_q    <= drv_d;
            ipaddr_q <= ipaddr_d;
            imiss_q  <= imiss_d;
            iinv_q   <= iinv_d;
            icache_q <= icache_d;
            dpaddr_q <= dpaddr_d;
            dmiss_q  <= dmiss_d;
            dinv_q   <= dinv_d;
            dmod_q   <= dmod_d;
            dcache_q <= dcache_d;
        end
    end

    assign bus.inst_gnt_o      = inst_gnt;
    assign bus.data_gnt_o      = data_gnt;
    assign bus.inst_rvalid_o   = irv_q;
    assign bus.data_rvalid_o   = drv_q;
    assign bus.inst_paddr_o    = ipaddr_q;
    assign bus.inst_miss_o     = imiss_q;
    assign bus.inst_invalid_o  = iinv_q;
    assign bus.inst_cache_o    = icache_q;
    assign bus.data_paddr_o    = dpaddr_q;
    assign bus.data_miss_o     = dmiss_q;
    assign bus.data_invalid_o  = dinv_q;
    assign bus.data_modified_o = dmod_q;
    assign bus.data_cache_o    = dcache_q;
    assign bus.tlb_valid_o     = valid_q;
    assign bus.tlb_vaddr_o     = vaddr_q;
    assign bus.tlb_ren_o       = ren_q;
    assign bus.tlb_wen_o       = wen_q;
endmodule

// File: doc/tlb_port_arbiter.md
# tlb_port_arbiter

Shares the single lookup port of the joint TLB between the instruction-fetch and data-memory requesters. Requests are accepted by a req/gnt handshake, with at most one lookup outstanding. Each accepted lookup is issued to the TLB for one cycle, and the fixed-latency result is registered back to the owning requester. Data has priority; a starvation counter guarantees instruction-fetch progress. Lookups are held off during TLB writes (TLBWI/TLBWR), and in-flight results are discarded on a pipeline flush.

## Interface
- LOOKUP_LAT, 1: cycles from the issue cycle to the TLB result-valid cycle; ≥1.
- STARVE_MAX, 4: consecutive contested data grants allowed before instruction fetch wins; ≥1.

- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- inst_req_i  in  1  fetch lookup request; held with inst_vaddr_i until granted.
- inst_vaddr_i  in  32  fetch virtual address.
- inst_gnt_o  out  1  fetch request accepted this cycle (combinational).
- inst_rvalid_o  out  1  one-cycle pulse: fetch result outputs updated.
- inst_paddr_o / inst_miss_o / inst_invalid_o / inst_cache_o  out  32/1/1/1  registered fetch result; sticky.
- data_req_i  in  1  data lookup request; held with vaddr/ren/wen until granted.
- data_vaddr_i  in  32  data virtual address.
- data_ren_i, data_wen_i  in  1  load / store qualifiers.
- data_gnt_o  out  1  data request accepted this cycle (combinational).
- data_rvalid_o  out  1  one-cycle pulse: data result outputs updated.
- data_paddr_o / data_miss_o / data_invalid_o / data_modified_o / data_cache_o  out  32/1/1/1/1  registered data result; sticky.
- flush_i  in  1  exception/ERET flush; aborts the outstanding lookup.
- tlb_write_i  in  1  TLBWI/TLBWR in progress; blocks new grants.
- tlb_valid_o  out  1  issue strobe to TLB (registered).
- tlb_vaddr_o  out  32  issued address (registered).
- tlb_ren_o, tlb_wen_o  out  1  issued qualifiers; both 0 for fetch.
- tlb_paddr_i / tlb_miss_i / tlb_invalid_i / tlb_modified_i / tlb_cache_i  in  32/1/1/1/1  TLB result, valid exactly LOOKUP_LAT cycles after the tlb_valid_o cycle. The TLB is fully pipelined with fixed latency.

## Operation
- States:
  - IDLE: may grant.
  - ISSUE: tlb_valid_o=1 for one cycle.
  - WAIT: down-counter from LOOKUP_LAT.
- Grant rules:
  - A grant occurs only in IDLE, with flush_i=0 and tlb_write_i=0. At most one gnt_o is high per cycle.
  - A single requester is granted directly.
  - When both requesters are active, data wins unless starve_cnt==STARVE_MAX; in that case fetch wins.
- Starvation counter:
  - starve_cnt increments on each data grant while inst_req_i=1, saturating at STARVE_MAX.
  - It clears on a fetch grant.
- Grant edge:
  - Latch vaddr and the owner bit.
  - Latch ren/wen for data; force 0 for fetch.
  - Go to ISSUE.
- ISSUE → WAIT with the counter at LOOKUP_LAT.
- WAIT:
  - Decrement each cycle.
  - When the TLB result is valid (LOOKUP_LAT cycles after ISSUE), sample the result into the owner's result registers.
  - Set the owner's rvalid for the next cycle and go to IDLE.
- IDLE is re-entered in the same edge that raises rvalid, so a new grant may coincide with the rvalid pulse.
- flush_i=1 in ISSUE or WAIT:
  - Next state is IDLE.
  - rvalid and the result-register update are suppressed, including when the flush coincides with the sampling cycle (flush wins).
  - No grant is made in the flush cycle.
- Stale TLB results from aborted lookups are never sampled, because sampling is timed only from the current issue.
- tlb_write_i does not affect an in-flight lookup; it only blocks grants.
- Result registers hold their value until the next unflushed response to the same requester.

## Timing
- Reset (asynchronous), immediately:
  - All outputs are 0, including gnt (combinational from state/inputs).
  - state=IDLE, starve_cnt=0, counter=0.
  - Reset during WAIT drops the lookup and no rvalid follows.
- Grant in cycle G:
  - tlb_valid_o=1 in G+1.
  - TLB result in G+1+LOOKUP_LAT.
  - rvalid=1 in G+2+LOOKUP_LAT.
- Maximum throughput: one lookup per LOOKUP_LAT+2 cycles.
- tlb_valid_o, tlb_vaddr_o, tlb_ren_o, tlb_wen_o:
  - Registered.
  - tlb_valid_o is 0 outside ISSUE.
  - vaddr/ren/wen hold the last issued values.
- rvalid pulses last exactly one cycle. inst_rvalid_o and data_rvalid_o are never high together.

## Test plan
- **Reset during lookup:** rst asserted mid-WAIT → all outputs 0 asynchronously; after release, the first request is granted in its first IDLE cycle; no spurious rvalid.
- **Single fetch lookup:** LOOKUP_LAT=1; inst_req with vaddr 0x8000_1000 at cycle 0; TLB returns paddr 0x0000_1000, cache=1 at cycle 2 → expect:
  - inst_gnt_o at 0;
  - tlb_valid_o at 1 with tlb_ren_o=tlb_wen_o=0;
  - inst_rvalid_o at 3 with inst_paddr_o=0x0000_1000, inst_cache_o=1;
  - data outputs unchanged.
- **Fairness under contention:** both requests held continuously, STARVE_MAX=4 → grant order D,D,D,D,I,D,D,D,D,I; each grant is spaced LOOKUP_LAT+2 cycles.
- **Flush abort:** flush_i in the sampling cycle of a data lookup → no data_rvalid_o; data_paddr_o keeps its old value. A fetch granted 1 cycle later returns its own TLB result, not the stale one.
- **TLB write hold-off:** tlb_write_i high for 3 cycles while data_req_i=1 → no data_gnt_o during those cycles; grant in the first cycle tlb_write_i=0.
- **Store miss:** data_wen_i=1, data_ren_i=0, vaddr 0x0040_2000; tlb_miss_i=1 → tlb_wen_o=1 in ISSUE; data_rvalid_o with data_miss_o=1.
